// File: rtl/synth_pkg.sv
// ---------------------------------------------------------------------------
// synth_pkg
// Shared definitions for the synth voice datapath.
//   - env_state_e    : envelope FSM state encoding (IDLE=0 .. RELEASE=4, 3 bits)
//   - ENV_WIDTH_DEF  : default envelope level / rate width
//   - OUTPUT_WIDTH_DEF : default oscillator sample width
//   - ENV_MAX_LEVEL  : full-scale envelope level at the default width
// ---------------------------------------------------------------------------
package synth_pkg;

  // Envelope FSM state encoding; values are fixed so they can be probed
  // and compared against software tables.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_e;

  localparam int ENV_WIDTH_DEF    = 16;
  localparam int OUTPUT_WIDTH_DEF = 12;

  localparam logic [ENV_WIDTH_DEF-1:0] ENV_MAX_LEVEL = 16'hFFFF;

endpackage : synth_pkg

// File: rtl/env_scale.sv
// ---------------------------------------------------------------------------
// env_scale
// Registered amplitude scaler: dout = (din * level) >> ENV_WIDTH, truncated,
// updated only on sample strobes. dout_valid pulses for one cycle per strobe.
//
// Ports
//   i_clk        : system clock
//   i_rst_n      : asynchronous active-low reset
//   i_sample_en  : one-cycle sample strobe
//   i_din        : unsigned oscillator sample (OUTPUT_WIDTH)
//   i_level      : envelope level in effect before this tick's update
//   o_dout       : scaled sample, registered (OUTPUT_WIDTH)
//   o_dout_valid : one-cycle pulse when o_dout updates
// ---------------------------------------------------------------------------
module env_scale
  import synth_pkg::*;
#(
  parameter int OUTPUT_WIDTH = OUTPUT_WIDTH_DEF,
  parameter int ENV_WIDTH    = ENV_WIDTH_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_sample_en,
  input  logic [OUTPUT_WIDTH-1:0] i_din,
  input  logic [ENV_WIDTH-1:0]    i_level,
  output logic [OUTPUT_WIDTH-1:0] o_dout,
  output logic                    o_dout_valid
);

  localparam int PROD_WIDTH = OUTPUT_WIDTH + ENV_WIDTH;

  logic [PROD_WIDTH-1:0]   w_product;
  logic [OUTPUT_WIDTH-1:0] r_dout;
  logic                    r_dout_valid;

  // Full-width product so no partial product bits are lost before truncation.
  assign w_product = {{ENV_WIDTH{1'b0}}, i_din} * {{OUTPUT_WIDTH{1'b0}}, i_level};

  // Output register: capture the scaled sample and raise valid on each strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dout       <= {OUTPUT_WIDTH{1'b0}};
      r_dout_valid <= 1'b0;
    end else if (i_sample_en) begin
      // Level is a 0..(2^EW-1)/2^EW fraction, so dropping the low EW bits
      // keeps the result within OUTPUT_WIDTH.
      r_dout       <= OUTPUT_WIDTH'(w_product >> ENV_WIDTH);
      r_dout_valid <= 1'b1;
    end else begin
      r_dout       <= r_dout;
      r_dout_valid <= 1'b0;
    end
  end

  assign o_dout       = r_dout;
  assign o_dout_valid = r_dout_valid;

endmodule : env_scale

// File: rtl/envelope_adsr.sv
// ---------------------------------------------------------------------------
// envelope_adsr
// Gate-driven ADSR amplitude envelope applied to the oscillator sample.
// All state advances only on sample_en; the output is scaled by the level
// that was in effect before the current tick's update.
//
// Build option
//   ENVELOPE_LEGATO_EN : when defined, a gate rise starts ATTACK from the
//                        current level (smooth retrigger). When undefined,
//                        the level is forced to 0 on the rise tick.
//
// Ports
//   main_clk      : system clock
//   reset         : asynchronous active-low reset
//   sample_en     : one-cycle sample strobe
//   gate          : note on (1) / note off (0)
//   attack_rate   : level increment per sample in ATTACK
//   decay_rate    : level decrement per sample in DECAY
//   sustain_level : hold level in SUSTAIN (tracked live)
//   release_rate  : level decrement per sample in RELEASE
//   din           : unsigned oscillator sample
//   dout          : scaled sample, registered
//   dout_valid    : one-cycle pulse when dout updates
//   env_level     : current envelope level, registered
//   busy          : high whenever the envelope is not IDLE, registered
// ---------------------------------------------------------------------------
module envelope_adsr
  import synth_pkg::*;
#(
  parameter int OUTPUT_WIDTH = OUTPUT_WIDTH_DEF,
  parameter int ENV_WIDTH    = ENV_WIDTH_DEF
) (
  input  logic                    main_clk,
  input  logic                    reset,
  input  logic                    sample_en,
  input  logic                    gate,
  input  logic [ENV_WIDTH-1:0]    attack_rate,
  input  logic [ENV_WIDTH-1:0]    decay_rate,
  input  logic [ENV_WIDTH-1:0]    sustain_level,
  input  logic [ENV_WIDTH-1:0]    release_rate,
  input  logic [OUTPUT_WIDTH-1:0] din,
  output logic [OUTPUT_WIDTH-1:0] dout,
  output logic                    dout_valid,
  output logic [ENV_WIDTH-1:0]    env_level,
  output logic                    busy
);

  localparam logic [ENV_WIDTH-1:0] LVL_MAX  = {ENV_WIDTH{1'b1}};
  localparam logic [ENV_WIDTH-1:0] LVL_ZERO = {ENV_WIDTH{1'b0}};

  env_state_e              r_state;
  env_state_e              w_state_nxt;
  logic [ENV_WIDTH-1:0]    r_level;
  logic [ENV_WIDTH-1:0]    w_level_nxt;
  logic                    r_gate_q;
  logic                    r_busy;

  logic                    w_rise;
  logic                    w_fall;
  logic                    w_fall_active;
  logic [ENV_WIDTH:0]      w_attack_sum;
  logic signed [ENV_WIDTH+1:0] w_decay_diff;
  logic signed [ENV_WIDTH+1:0] w_sustain_ext;

  assign w_rise = gate & ~r_gate_q;
  assign w_fall = ~gate & r_gate_q;

  // A fall only matters while the note is sounding under gate control.
  assign w_fall_active = w_fall & ((r_state == ST_ATTACK) ||
                                   (r_state == ST_DECAY)  ||
                                   (r_state == ST_SUSTAIN));

  // One extra bit so the attack overshoot past full scale is visible.
  assign w_attack_sum = {1'b0, r_level} + {1'b0, attack_rate};

  // Two extra bits so a decay step below zero compares correctly as signed.
  assign w_decay_diff  = $signed({2'b00, r_level}) - $signed({2'b00, decay_rate});
  assign w_sustain_ext = $signed({2'b00, sustain_level});

  // Next-state and next-level evaluation for one sample tick.
  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    if (w_rise) begin
      // Rise beats every other transition, including decay reaching sustain.
      w_state_nxt = ST_ATTACK;
`ifdef ENVELOPE_LEGATO_EN
      w_level_nxt = r_level;
`else
      w_level_nxt = LVL_ZERO;
`endif
    end else if (w_fall_active) begin
      // Enter RELEASE holding the level; the first decrement is next tick.
      w_state_nxt = ST_RELEASE;
      w_level_nxt = r_level;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_IDLE;
          w_level_nxt = LVL_ZERO;
        end
        ST_ATTACK: begin
          if (w_attack_sum >= {1'b0, LVL_MAX}) begin
            w_state_nxt = ST_DECAY;
            w_level_nxt = LVL_MAX;
          end else begin
            w_state_nxt = ST_ATTACK;
            w_level_nxt = w_attack_sum[ENV_WIDTH-1:0];
          end
        end
        ST_DECAY: begin
          if (w_decay_diff <= w_sustain_ext) begin
            w_state_nxt = ST_SUSTAIN;
            w_level_nxt = sustain_level;
          end else begin
            w_state_nxt = ST_DECAY;
            w_level_nxt = w_decay_diff[ENV_WIDTH-1:0];
          end
        end
        ST_SUSTAIN: begin
          // Track live changes of the sustain setting every tick.
          w_state_nxt = ST_SUSTAIN;
          w_level_nxt = sustain_level;
        end
        ST_RELEASE: begin
          if (r_level <= release_rate) begin
            w_state_nxt = ST_IDLE;
            w_level_nxt = LVL_ZERO;
          end else begin
            w_state_nxt = ST_RELEASE;
            w_level_nxt = r_level - release_rate;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_level_nxt = LVL_ZERO;
        end
      endcase
    end
  end

  // Envelope FSM state, level, gate history and busy flag, advanced per tick.
  always_ff @(posedge main_clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_level  <= LVL_ZERO;
      r_gate_q <= 1'b0;
      r_busy   <= 1'b0;
    end else if (sample_en) begin
      r_state  <= w_state_nxt;
      r_level  <= w_level_nxt;
      r_gate_q <= gate;
      r_busy   <= (w_state_nxt != ST_IDLE);
    end else begin
      r_state  <= r_state;
      r_level  <= r_level;
      r_gate_q <= r_gate_q;
      r_busy   <= r_busy;
    end
  end

  // Scale with the pre-update level so dout reflects the level that was
  // visible on env_level when the strobe arrived.
  env_scale #(
    .OUTPUT_WIDTH (OUTPUT_WIDTH),
    .ENV_WIDTH    (ENV_WIDTH)
  ) u_env_scale (
    .i_clk        (main_clk),
    .i_rst_n      (reset),
    .i_sample_en  (sample_en),
    .i_din        (din),
    .i_level      (r_level),
    .o_dout       (dout),
    .o_dout_valid (dout_valid)
  );

  assign env_level = r_level;
  assign busy      = r_busy;

endmodule : envelope_adsr

// File: tb/tb_envelope_adsr.sv
// ---------------------------------------------------------------------------
// tb_envelope_adsr
// Scoreboard bench: each sample strobe pushes the hand-computed expected
// dout / env_level / busy; a monitor pops and compares on every dout_valid.
// Expected values depend on ENVELOPE_LEGATO_EN for the retrigger phase.
// ---------------------------------------------------------------------------
module tb_envelope_adsr;

`ifdef ENVELOPE_LEGATO_EN
  localparam bit LEGATO = 1'b1;
`else
  localparam bit LEGATO = 1'b0;
`endif

  logic        main_clk;
  logic        reset;
  logic        sample_en;
  logic        gate;
  logic [15:0] attack_rate;
  logic [15:0] decay_rate;
  logic [15:0] sustain_level;
  logic [15:0] release_rate;
  logic [11:0] din;
  logic [11:0] dout;
  logic        dout_valid;
  logic [15:0] env_level;
  logic        busy;

  typedef struct {
    logic [11:0] dout;
    logic [15:0] level;
    logic        busy;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   tick_id  = 0;

  envelope_adsr dut (
    .main_clk      (main_clk),
    .reset         (reset),
    .sample_en     (sample_en),
    .gate          (gate),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .sustain_level (sustain_level),
    .release_rate  (release_rate),
    .din           (din),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .env_level     (env_level),
    .busy          (busy)
  );

  initial main_clk = 1'b0;
  always #5 main_clk = ~main_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // One sample strobe; back-to-back calls give consecutive strobes.
  task automatic tick(input logic g, input logic [11:0] d,
                      input logic [11:0] ed, input logic [15:0] el, input logic eb);
    exp_t e;
    @(negedge main_clk);
    gate      = g;
    din       = d;
    sample_en = 1'b1;
    e.dout  = ed;
    e.level = el;
    e.busy  = eb;
    e.id    = tick_id;
    tick_id++;
    exp_q.push_back(e);
  endtask

  task automatic gap();
    @(negedge main_clk);
    sample_en = 1'b0;
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge occurs.
  task automatic async_reset_check(input string tag);
    #2 reset = 1'b0;
    #1;
    check({tag, "_dout"},       32'(dout),       32'h0);
    check({tag, "_env_level"},  32'(env_level),  32'h0);
    check({tag, "_busy"},       32'(busy),       32'h0);
    check({tag, "_dout_valid"}, 32'(dout_valid), 32'h0);
    repeat (2) @(negedge main_clk);
    reset = 1'b1;
  endtask

  // Monitor: compare every presented output against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge main_clk);
      if (dout_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_dout_valid: got pulse with dout=0x%0h, expected no pulse", dout);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("dout[t%0d]", e.id),      32'(dout),      32'(e.dout));
          check($sformatf("env_level[t%0d]", e.id), 32'(env_level), 32'(e.level));
          check($sformatf("busy[t%0d]", e.id),      32'(busy),      32'(e.busy));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b0;
    sample_en     = 1'b0;
    gate          = 1'b0;
    din           = 12'h000;
    attack_rate   = 16'h4000;
    decay_rate    = 16'h3000;
    sustain_level = 16'h8000;
    release_rate  = 16'h3000;

    repeat (2) @(negedge main_clk);
    check("rst_dout",       32'(dout),       32'h0);
    check("rst_env_level",  32'(env_level),  32'h0);
    check("rst_busy",       32'(busy),       32'h0);
    check("rst_dout_valid", 32'(dout_valid), 32'h0);
    @(negedge main_clk);
    reset = 1'b1;

    // Attack 0 -> FFFF, decay to sustain 0x8000 (din 0x800 => dout = level>>5).
    tick(1'b1, 12'h800, 12'h000, 16'h0000, 1'b1); gap();
    tick(1'b1, 12'h800, 12'h000, 16'h4000, 1'b1); gap();
    tick(1'b1, 12'h800, 12'h200, 16'h8000, 1'b1); gap();
    tick(1'b1, 12'h800, 12'h400, 16'hC000, 1'b1);
    tick(1'b1, 12'h800, 12'h600, 16'hFFFF, 1'b1);
    tick(1'b1, 12'h800, 12'h7FF, 16'hCFFF, 1'b1);
    tick(1'b1, 12'h800, 12'h67F, 16'h9FFF, 1'b1);
    tick(1'b1, 12'h800, 12'h4FF, 16'h8000, 1'b1);
    tick(1'b1, 12'hFFF, 12'h7FF, 16'h8000, 1'b1); gap();
    // Live sustain change, then back.
    sustain_level = 16'h6000;
    tick(1'b1, 12'h800, 12'h400, 16'h6000, 1'b1); gap();
    sustain_level = 16'h8000;
    tick(1'b1, 12'h800, 12'h300, 16'h8000, 1'b1);
    // Fall in SUSTAIN, release to IDLE.
    tick(1'b0, 12'h800, 12'h400, 16'h8000, 1'b1);
    tick(1'b0, 12'h800, 12'h400, 16'h5000, 1'b1);
    tick(1'b0, 12'h800, 12'h280, 16'h2000, 1'b1);
    tick(1'b0, 12'h800, 12'h100, 16'h0000, 1'b0);
    tick(1'b0, 12'hFFF, 12'h000, 16'h0000, 1'b0); gap();

    // Second note: fall in ATTACK, release to 0x5000, then retrigger.
    tick(1'b1, 12'h800, 12'h000, 16'h0000, 1'b1);
    tick(1'b1, 12'h800, 12'h000, 16'h4000, 1'b1);
    tick(1'b1, 12'h800, 12'h200, 16'h8000, 1'b1);
    tick(1'b0, 12'h800, 12'h400, 16'h8000, 1'b1);
    tick(1'b0, 12'h800, 12'h400, 16'h5000, 1'b1);
    tick(1'b1, 12'h800, 12'h280, LEGATO ? 16'h5000 : 16'h0000, 1'b1);
    tick(1'b1, 12'h800, LEGATO ? 12'h280 : 12'h000, LEGATO ? 16'h9000 : 16'h4000, 1'b1);
    tick(1'b1, 12'h800, LEGATO ? 12'h480 : 12'h200, LEGATO ? 16'hD000 : 16'h8000, 1'b1);
    tick(1'b1, 12'h800, LEGATO ? 12'h680 : 12'h400, LEGATO ? 16'hFFFF : 16'hC000, 1'b1);
    gap();
    async_reset_check("rst_mid_note");

    // After reset gate_q=0 with gate held high: first tick is a fresh rise.
    attack_rate = 16'hFFFF;
    decay_rate  = 16'h8000;
    tick(1'b1, 12'h800, 12'h000, 16'h0000, 1'b1);
    tick(1'b1, 12'h800, 12'h000, 16'hFFFF, 1'b1);
    tick(1'b1, 12'h800, 12'h7FF, 16'h8000, 1'b1);
    tick(1'b1, 12'h800, 12'h400, 16'h8000, 1'b1);
    gap();
    async_reset_check("rst_mid_sustain");

    repeat (4) @(negedge main_clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_envelope_adsr
